mc_ctrl: RTL and testbench
==========================

MC_CTRL -- requirements
Module: mc_ctrl

Interface
REQ-001 The block SHALL have a single clock and a synchronous, active-high reset; the ports are listed below, clock and reset first.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 reset  in  1  synchronous, active-high.
REQ-004 opcode  in  6  Instr[31:26] from the instruction register; stable from DECODE through instruction end.
REQ-005 funct  in  6  Instr[5:0] from the instruction register; same stability as opcode.
REQ-006 zero  in  1  ALU equal flag; sampled only in BRANCH.
REQ-007 pc_we  out  1  PC register load enable.
REQ-008 npc_sel  out  2  next-PC select: 00 PC+4, 01 branch (imm16), 10 jump (imm26), 11 register (jr).
REQ-009 ir_we  out  1  instruction register load enable.
REQ-010 reg_we  out  1  GRF write enable.
REQ-011 reg_dst  out  2  write address: 00 rt, 01 rd, 10 constant 31.
REQ-012 wd_sel  out  2  GRF write data: 00 ALU result, 01 memory data, 10 PC+4 link.
REQ-013 alu_src  out  1  0 register rt, 1 zero-extended imm16.
REQ-014 alu_op  out  2  00 add, 01 sub, 10 or, 11 lui (imm16<<16).
REQ-015 mem_we  out  1  DM write enable.
REQ-016 retire  out  1  one-cycle pulse in the last cycle of every instruction.
REQ-017 retire_cnt  out  32  count of retired instructions.
REQ-018 state  out  4  current FSM state, for debug.

Function
REQ-019 The FSM SHALL use the states FETCH, DECODE, EXEC, ALU_WB, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR and BRANCH; all outputs SHALL be Moore-style, derived from state plus opcode/funct; zero SHALL be the only exception, and it is used only in BRANCH.
REQ-020 Outputs not listed for a state SHALL be 0.
REQ-021 FETCH: ir_we=1, pc_we=1, npc_sel=00; next state DECODE.
REQ-022 DECODE, j (000010): pc_we=1, npc_sel=10, retire=1; next state FETCH.
REQ-023 DECODE, jal (000011): pc_we=1, npc_sel=10, reg_we=1, reg_dst=10, wd_sel=10, retire=1; next state FETCH.
REQ-024 DECODE, jr (op 000000, funct 001000): pc_we=1, npc_sel=11, retire=1; next state FETCH.
REQ-025 DECODE, add (funct 100000), sub (funct 100010), ori (001101) or lui (001111): next state EXEC.
REQ-026 DECODE, lw (100011) or sw (101011): next state MEM_ADDR.
REQ-027 DECODE, beq (000100): next state BRANCH.
REQ-028 DECODE, any other opcode/funct (including nop 0x00000000): treated as nop, retire=1, no writes; next state FETCH.
REQ-029 EXEC: alu_op/alu_src per instruction (add 00/0, sub 01/0, ori 10/1, lui 11/1); next state ALU_WB.
REQ-030 ALU_WB: same alu_op/alu_src, reg_we=1, wd_sel=00, reg_dst=01 for R-type else 00, retire=1; next state FETCH.
REQ-031 MEM_ADDR: alu_op=00, alu_src=1; next state MEM_RD for lw, MEM_WR for sw.
REQ-032 MEM_RD: alu_op=00, alu_src=1; next state MEM_WB.
REQ-033 MEM_WB: reg_we=1, reg_dst=00, wd_sel=01, retire=1; next state FETCH.
REQ-034 MEM_WR: mem_we=1, alu_op=00, alu_src=1, retire=1; next state FETCH.
REQ-035 BRANCH: alu_op=01, alu_src=0, pc_we=zero, npc_sel=01, retire=1; next state FETCH.
REQ-036 Latency in cycles: j/jal/jr/nop 2; beq 3; R-type, ori, lui and sw 4; lw 5.
REQ-037 Each retire pulse SHALL increment retire_cnt by 1, wrapping from 0xFFFFFFFF to 0.
REQ-038 At most one of reg_we and mem_we SHALL be 1 in any cycle.
REQ-039 pc_we SHALL be 1 at most once per instruction after FETCH.

Reset
REQ-040 While reset=1 at a clock edge: state SHALL load FETCH and retire_cnt SHALL load 0.
REQ-041 In any cycle where reset=1, all enables and retire SHALL be 0 and state SHALL read FETCH.
REQ-042 Reset asserted mid-instruction SHALL abandon that instruction with no write; the first cycle after deassertion SHALL be FETCH.

Structure
REQ-043 Package mc_ctrl_pkg SHALL hold the state enumeration, the opcode/funct constants, and the npc_sel, alu_op, reg_dst and wd_sel encodings.
REQ-044 Decode SHALL be a combinational sub-module mc_decode that classifies opcode/funct into one-hot instruction classes consumed by the FSM.

Verification
REQ-045 Reset, then add (op 0, funct 100000) -> state sequence FETCH, DECODE, EXEC, ALU_WB; reg_we=1 and reg_dst=01 only in ALU_WB; retire_cnt=1.
REQ-046 lw then sw -> lw takes 5 cycles (wd_sel=01 in MEM_WB), sw takes 4 cycles (mem_we=1 only in MEM_WR); retire_cnt=2.
REQ-047 beq with zero=1, then beq with zero=0 -> pc_we=1, npc_sel=01 in BRANCH for the first; pc_we=0 for the second.
REQ-048 jal then jr -> jal: reg_dst=10, wd_sel=10, npc_sel=10 in DECODE; jr: npc_sel=11; each takes 2 cycles.
REQ-049 Unknown opcode 0x3F -> 2 cycles, no reg_we/mem_we, retire=1.
REQ-050 Reset in MEM_RD of lw -> no reg_we; FETCH follows deassertion; retire_cnt=0.
REQ-051 retire_cnt forced near 0xFFFFFFFF by running 0xFFFFFFFF nops (or by a bench backdoor), then one more instruction -> retire_cnt wraps to 0.

Source files
------------

// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle controller: state codes, instruction
// fields, datapath select values and the decoded-instruction class bundle.
package mc_ctrl_pkg;

  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_EXEC     = 4'd2;
  localparam logic [3:0] S_ALU_WB   = 4'd3;
  localparam logic [3:0] S_MEM_ADDR = 4'd4;
  localparam logic [3:0] S_MEM_RD   = 4'd5;
  localparam logic [3:0] S_MEM_WB   = 4'd6;
  localparam logic [3:0] S_MEM_WR   = 4'd7;
  localparam logic [3:0] S_BRANCH   = 4'd8;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_JR  = 6'b001000;
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;

  localparam logic [1:0] NPC_PC4 = 2'b00;
  localparam logic [1:0] NPC_BR  = 2'b01;
  localparam logic [1:0] NPC_J   = 2'b10;
  localparam logic [1:0] NPC_JR  = 2'b11;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_OR  = 2'b10;
  localparam logic [1:0] ALU_LUI = 2'b11;

  localparam logic [1:0] DST_RT = 2'b00;
  localparam logic [1:0] DST_RD = 2'b01;
  localparam logic [1:0] DST_RA = 2'b10;

  localparam logic [1:0] WD_ALU  = 2'b00;
  localparam logic [1:0] WD_MEM  = 2'b01;
  localparam logic [1:0] WD_LINK = 2'b10;

  // Exactly one bit is set for any opcode/funct; nop covers every unknown encoding.
  typedef struct packed {
    logic nop;
    logic j;
    logic jal;
    logic jr;
    logic add;
    logic sub;
    logic ori;
    logic lui;
    logic lw;
    logic sw;
    logic beq;
  } iclass_t;

  typedef struct packed {
    logic       pc_we;
    logic [1:0] npc_sel;
    logic       ir_we;
    logic       reg_we;
    logic [1:0] reg_dst;
    logic [1:0] wd_sel;
    logic       alu_src;
    logic [1:0] alu_op;
    logic       mem_we;
    logic       retire;
  } ctrl_t;

  // {alu_src, alu_op} for the ALU-class instructions; zero for anything else.
  function automatic logic [2:0] alu_sel(input iclass_t c);
    logic [2:0] r;
    r = 3'b000;
    if (c.add) r = {1'b0, ALU_ADD};
    if (c.sub) r = {1'b0, ALU_SUB};
    if (c.ori) r = {1'b1, ALU_OR};
    if (c.lui) r = {1'b1, ALU_LUI};
    return r;
  endfunction

endpackage

// File: rtl/mc_decode.sv
// Combinational instruction classifier: opcode/funct to a one-hot class vector.
module mc_decode
  import mc_ctrl_pkg::*;
(
  input  logic [5:0] i_opcode,
  input  logic [5:0] i_funct,
  output iclass_t    o_class
);

  always_comb begin
    o_class = '0;
    case (i_opcode)
      OP_RTYPE: begin
        case (i_funct)
          FN_ADD:  o_class.add = 1'b1;
          FN_SUB:  o_class.sub = 1'b1;
          FN_JR:   o_class.jr  = 1'b1;
          default: o_class.nop = 1'b1;
        endcase
      end
      OP_J:    o_class.j   = 1'b1;
      OP_JAL:  o_class.jal = 1'b1;
      OP_BEQ:  o_class.beq = 1'b1;
      OP_ORI:  o_class.ori = 1'b1;
      OP_LUI:  o_class.lui = 1'b1;
      OP_LW:   o_class.lw  = 1'b1;
      OP_SW:   o_class.sw  = 1'b1;
      default: o_class.nop = 1'b1;
    endcase
  end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS-subset control FSM with Moore outputs and a retire counter.
//
// state    | meaning
// FETCH    | load IR, PC <= PC+4
// DECODE   | classify; jumps, jr and nops finish here
// EXEC     | ALU operates on rs and rt/imm16
// ALU_WB   | write ALU result to GRF
// MEM_ADDR | form lw/sw address (base + imm16)
// MEM_RD   | data memory read
// MEM_WB   | write loaded data to rt
// MEM_WR   | data memory write
// BRANCH   | beq compare, PC <= target when zero
module mc_ctrl
  import mc_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  opcode,
  input  logic [5:0]  funct,
  input  logic        zero,
  output logic        pc_we,
  output logic [1:0]  npc_sel,
  output logic        ir_we,
  output logic        reg_we,
  output logic [1:0]  reg_dst,
  output logic [1:0]  wd_sel,
  output logic        alu_src,
  output logic [1:0]  alu_op,
  output logic        mem_we,
  output logic        retire,
  output logic [31:0] retire_cnt,
  output logic [3:0]  state
);

  logic [3:0]  r_state;
  logic [31:0] r_retire_cnt;
  logic [3:0]  w_next;
  iclass_t     w_class;
  ctrl_t       w_ctrl;
  ctrl_t       w_out;
  logic [2:0]  w_alu;

  mc_decode u_decode (
    .i_opcode (opcode),
    .i_funct  (funct),
    .o_class  (w_class)
  );

  assign w_alu = alu_sel(w_class);

  always_comb begin
    w_next = S_FETCH;
    case (r_state)
      S_FETCH:  w_next = S_DECODE;
      S_DECODE: begin
        if (w_class.add || w_class.sub || w_class.ori || w_class.lui)
          w_next = S_EXEC;
        else if (w_class.lw || w_class.sw)
          w_next = S_MEM_ADDR;
        else if (w_class.beq)
          w_next = S_BRANCH;
        else
          w_next = S_FETCH;
      end
      S_EXEC:     w_next = S_ALU_WB;
      S_ALU_WB:   w_next = S_FETCH;
      S_MEM_ADDR: w_next = w_class.lw ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD:   w_next = S_MEM_WB;
      S_MEM_WB:   w_next = S_FETCH;
      S_MEM_WR:   w_next = S_FETCH;
      S_BRANCH:   w_next = S_FETCH;
      default:    w_next = S_FETCH;
    endcase
  end

  always_comb begin
    w_ctrl = '0;
    case (r_state)
      S_FETCH: begin
        w_ctrl.ir_we   = 1'b1;
        w_ctrl.pc_we   = 1'b1;
        w_ctrl.npc_sel = NPC_PC4;
      end
      S_DECODE: begin
        if (w_class.j || w_class.jal) begin
          w_ctrl.pc_we   = 1'b1;
          w_ctrl.npc_sel = NPC_J;
          w_ctrl.retire  = 1'b1;
        end
        if (w_class.jal) begin
          w_ctrl.reg_we  = 1'b1;
          w_ctrl.reg_dst = DST_RA;
          w_ctrl.wd_sel  = WD_LINK;
        end
        if (w_class.jr) begin
          w_ctrl.pc_we   = 1'b1;
          w_ctrl.npc_sel = NPC_JR;
          w_ctrl.retire  = 1'b1;
        end
        if (w_class.nop)
          w_ctrl.retire = 1'b1;
      end
      S_EXEC: begin
        w_ctrl.alu_src = w_alu[2];
        w_ctrl.alu_op  = w_alu[1:0];
      end
      S_ALU_WB: begin
        w_ctrl.alu_src = w_alu[2];
        w_ctrl.alu_op  = w_alu[1:0];
        w_ctrl.reg_we  = 1'b1;
        w_ctrl.wd_sel  = WD_ALU;
        w_ctrl.reg_dst = (w_class.add || w_class.sub) ? DST_RD : DST_RT;
        w_ctrl.retire  = 1'b1;
      end
      S_MEM_ADDR, S_MEM_RD: begin
        w_ctrl.alu_op  = ALU_ADD;
        w_ctrl.alu_src = 1'b1;
      end
      S_MEM_WB: begin
        w_ctrl.reg_we  = 1'b1;
        w_ctrl.reg_dst = DST_RT;
        w_ctrl.wd_sel  = WD_MEM;
        w_ctrl.retire  = 1'b1;
      end
      S_MEM_WR: begin
        w_ctrl.mem_we  = 1'b1;
        w_ctrl.alu_op  = ALU_ADD;
        w_ctrl.alu_src = 1'b1;
        w_ctrl.retire  = 1'b1;
      end
      S_BRANCH: begin
        w_ctrl.alu_op  = ALU_SUB;
        w_ctrl.alu_src = 1'b0;
        w_ctrl.pc_we   = zero;
        w_ctrl.npc_sel = NPC_BR;
        w_ctrl.retire  = 1'b1;
      end
      default: w_ctrl = '0;
    endcase
  end

  // Reset masks every output immediately so an abandoned instruction writes nothing.
  assign w_out = reset ? '0 : w_ctrl;

  assign pc_we      = w_out.pc_we;
  assign npc_sel    = w_out.npc_sel;
  assign ir_we      = w_out.ir_we;
  assign reg_we     = w_out.reg_we;
  assign reg_dst    = w_out.reg_dst;
  assign wd_sel     = w_out.wd_sel;
  assign alu_src    = w_out.alu_src;
  assign alu_op     = w_out.alu_op;
  assign mem_we     = w_out.mem_we;
  assign retire     = w_out.retire;
  assign retire_cnt = r_retire_cnt;
  assign state      = reset ? S_FETCH : r_state;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_FETCH;
      r_retire_cnt <= 32'd0;
    end else begin
      r_state <= w_next;
      if (w_out.retire)
        r_retire_cnt <= r_retire_cnt + 32'd1;
    end
  end

endmodule

// File: tb/tb_mc_ctrl.sv
// Bench for mc_ctrl: per-instruction expected output traces built from the
// instruction table, checked every cycle, plus literal counter checkpoints.
module tb_mc_ctrl;
  import mc_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  opcode, funct;
  logic        zero;
  logic        pc_we, ir_we, reg_we, alu_src, mem_we, retire;
  logic [1:0]  npc_sel, reg_dst, wd_sel, alu_op;
  logic [31:0] retire_cnt;
  logic [3:0]  state;

  mc_ctrl dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
    .pc_we(pc_we), .npc_sel(npc_sel), .ir_we(ir_we), .reg_we(reg_we),
    .reg_dst(reg_dst), .wd_sel(wd_sel), .alu_src(alu_src), .alu_op(alu_op),
    .mem_we(mem_we), .retire(retire), .retire_cnt(retire_cnt), .state(state)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [17:0] vec;
    logic        rst;
    logic        ld;
    logic [31:0] ld_val;
  } exp_t;

  exp_t        exp_q[$];
  logic [17:0] tr[$];
  int          errors = 0;
  int          checks = 0;
  logic [31:0] model_cnt = 32'd0;
  logic        cnt_known = 1'b0;
  logic        bd_pend = 1'b0;
  logic [31:0] bd_val = 32'd0;

  logic [17:0] dut_vec;
  assign dut_vec = {state, pc_we, npc_sel, ir_we, reg_we, reg_dst, wd_sel,
                    alu_src, alu_op, mem_we, retire};

  function automatic logic [17:0] v(input logic [3:0] st, input logic pcwe,
      input logic [1:0] npc, input logic irwe, input logic rwe, input logic [1:0] dst,
      input logic [1:0] wd, input logic asrc, input logic [1:0] aop,
      input logic mwe, input logic ret);
    return {st, pcwe, npc, irwe, rwe, dst, wd, asrc, aop, mwe, ret};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected per-cycle outputs of one instruction, from the instruction table.
  task automatic build(input logic [5:0] op, input logic [5:0] fn, input logic z);
    logic       is_r, alu_class;
    logic [1:0] aop;
    logic       asrc;
    is_r = (op == 6'h00);
    alu_class = (is_r && (fn == 6'h20 || fn == 6'h22)) || op == 6'h0D || op == 6'h0F;
    aop = is_r ? ((fn == 6'h22) ? 2'b01 : 2'b00) : ((op == 6'h0D) ? 2'b10 : 2'b11);
    asrc = !is_r;
    tr.delete();
    tr.push_back(v(S_FETCH, 1, 2'b00, 1, 0, 2'b00, 2'b00, 0, 2'b00, 0, 0));
    if (op == 6'h02)
      tr.push_back(v(S_DECODE, 1, 2'b10, 0, 0, 2'b00, 2'b00, 0, 2'b00, 0, 1));
    else if (op == 6'h03)
      tr.push_back(v(S_DECODE, 1, 2'b10, 0, 1, 2'b10, 2'b10, 0, 2'b00, 0, 1));
    else if (is_r && fn == 6'h08)
      tr.push_back(v(S_DECODE, 1, 2'b11, 0, 0, 2'b00, 2'b00, 0, 2'b00, 0, 1));
    else if (alu_class) begin
      tr.push_back(v(S_DECODE, 0, 2'b00, 0, 0, 2'b00, 2'b00, 0, 2'b00, 0, 0));
      tr.push_back(v(S_EXEC,   0, 2'b00, 0, 0, 2'b00, 2'b00, asrc, aop, 0, 0));
      tr.push_back(v(S_ALU_WB, 0, 2'b00, 0, 1, is_r ? 2'b01 : 2'b00, 2'b00, asrc, aop, 0, 1));
    end else if (op == 6'h23) begin
      tr.push_back(v(S_DECODE,   0, 2'b00, 0, 0, 2'b00, 2'b00, 0, 2'b00, 0, 0));
      tr.push_back(v(S_MEM_ADDR, 0, 2'b00, 0, 0, 2'b00, 2'b00, 1, 2'b00, 0, 0));
      tr.push_back(v(S_MEM_RD,   0, 2'b00, 0, 0, 2'b00, 2'b00, 1, 2'b00, 0, 0));
      tr.push_back(v(S_MEM_WB,   0, 2'b00, 0, 1, 2'b00, 2'b01, 0, 2'b00, 0, 1));
    end else if (op == 6'h2B) begin
      tr.push_back(v(S_DECODE,   0, 2'b00, 0, 0, 2'b00, 2'b00, 0, 2'b00, 0, 0));
      tr.push_back(v(S_MEM_ADDR, 0, 2'b00, 0, 0, 2'b00, 2'b00, 1, 2'b00, 0, 0));
      tr.push_back(v(S_MEM_WR,   0, 2'b00, 0, 0, 2'b00, 2'b00, 1, 2'b00, 1, 1));
    end else if (op == 6'h04) begin
      tr.push_back(v(S_DECODE, 0, 2'b00, 0, 0, 2'b00, 2'b00, 0, 2'b00, 0, 0));
      tr.push_back(v(S_BRANCH, z, 2'b01, 0, 0, 2'b00, 2'b00, 0, 2'b01, 0, 1));
    end else
      tr.push_back(v(S_DECODE, 0, 2'b00, 0, 0, 2'b00, 2'b00, 0, 2'b00, 0, 1));
  endtask

  task automatic push(input logic [17:0] vec, input logic rst);
    exp_t e;
    e.vec = vec;
    e.rst = rst;
    e.ld = bd_pend;
    e.ld_val = bd_val;
    bd_pend = 1'b0;
    exp_q.push_back(e);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Runs one instruction; abort_at >= 0 asserts reset in that cycle instead.
  task automatic run(input string name, input logic [5:0] op, input logic [5:0] fn,
                     input logic z, input int exp_len, input int abort_at);
    build(op, fn, z);
    check({name, "_latency"}, tr.size(), exp_len);
    opcode = op;
    funct = fn;
    zero = z;
    foreach (tr[i]) begin
      if (i == abort_at) begin
        reset = 1'b1;
        push(v(S_FETCH, 0, 2'b00, 0, 0, 2'b00, 2'b00, 0, 2'b00, 0, 0), 1'b1);
        next_cycle();
        reset = 1'b0;
        return;
      end
      push(tr[i], 1'b0);
      next_cycle();
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (e.ld) model_cnt = e.ld_val;
      check("outputs", {14'd0, dut_vec}, {14'd0, e.vec});
      check("single_write", {31'd0, reg_we & mem_we}, 32'd0);
      if (cnt_known) check("retire_cnt", retire_cnt, model_cnt);
      if (e.rst) begin
        model_cnt = 32'd0;
        cnt_known = 1'b1;
      end else if (e.vec[0])
        model_cnt = model_cnt + 32'd1;
    end
  end

  initial begin
    reset = 1'b1;
    opcode = 6'h00;
    funct = 6'h00;
    zero = 1'b0;
    next_cycle();
    for (int i = 0; i < 2; i++) begin
      push(v(S_FETCH, 0, 2'b00, 0, 0, 2'b00, 2'b00, 0, 2'b00, 0, 0), 1'b1);
      next_cycle();
    end
    reset = 1'b0;
    check("cnt_after_reset", retire_cnt, 32'd0);

    run("add", 6'h00, 6'h20, 1'b0, 4, -1);
    check("cnt_after_add", retire_cnt, 32'd1);
    run("lw", 6'h23, 6'h00, 1'b0, 5, -1);
    run("sw", 6'h2B, 6'h00, 1'b0, 4, -1);
    check("cnt_after_lw_sw", retire_cnt, 32'd3);
    run("beq_taken", 6'h04, 6'h00, 1'b1, 3, -1);
    run("beq_not", 6'h04, 6'h00, 1'b0, 3, -1);
    run("jal", 6'h03, 6'h00, 1'b0, 2, -1);
    run("jr", 6'h00, 6'h08, 1'b0, 2, -1);
    run("j", 6'h02, 6'h00, 1'b0, 2, -1);
    run("sub", 6'h00, 6'h22, 1'b0, 4, -1);
    run("ori", 6'h0D, 6'h00, 1'b0, 4, -1);
    run("lui", 6'h0F, 6'h15, 1'b0, 4, -1);
    run("nop", 6'h00, 6'h00, 1'b0, 2, -1);
    run("unknown_op", 6'h3F, 6'h00, 1'b0, 2, -1);
    run("unknown_fn", 6'h00, 6'h2A, 1'b0, 2, -1);
    check("cnt_after_mix", retire_cnt, 32'd14);

    run("lw_abort", 6'h23, 6'h00, 1'b0, 5, 3);
    check("cnt_after_abort", retire_cnt, 32'd0);
    run("add_after_abort", 6'h00, 6'h20, 1'b0, 4, -1);
    check("cnt_post_abort_add", retire_cnt, 32'd1);

    dut.r_retire_cnt = 32'hFFFF_FFFE;
    bd_pend = 1'b1;
    bd_val = 32'hFFFF_FFFE;
    run("nop_wrap1", 6'h00, 6'h00, 1'b0, 2, -1);
    check("cnt_at_max", retire_cnt, 32'hFFFF_FFFF);
    run("nop_wrap2", 6'h00, 6'h00, 1'b0, 2, -1);
    check("cnt_wrapped", retire_cnt, 32'd0);
    run("ori_post_wrap", 6'h0D, 6'h00, 1'b0, 4, -1);
    check("cnt_post_wrap", retire_cnt, 32'd1);

    next_cycle();
    next_cycle();
    check("queue_drained", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
